// File: rtl/mlp_neuron_mac.sv
// Time-shared fixed-point MLP neuron: serial signed MAC over N_INPUTS beats,
// then bias add, rescale, saturation and optional ReLU, one result per start.
module mlp_neuron_mac #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int N_INPUTS = 784,
    parameter int IDX_W    = 16,
    parameter int NID_W    = 8,
    parameter int ACC_W    = 48,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NID_W-1:0]        neuron_id,
    input  logic [DATA_W-1:0]       bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NID_W+IDX_W-1:0]  w_addr,
    input  logic [DATA_W-1:0]       w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state_r;
    state_t                     state_s;
    logic signed [ACC_W-1:0]    acc_r;
    logic [IDX_W-1:0]           idx_r;
    logic [NID_W-1:0]           nid_r;
    logic [DATA_W-1:0]          result_r;

    logic                       beat_s;
    logic                       last_s;
    logic signed [2*DATA_W-1:0] in_ext_s;
    logic signed [2*DATA_W-1:0] w_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    bias_ext_s;
    logic signed [ACC_W-1:0]    acc_bias_s;

    // Clamp the rescaled accumulator into the result range, then apply ReLU.
    function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        if (RELU_EN && r[DATA_W-1]) begin
            r = '0;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Datapath arithmetic: full-width signed product and Q-aligned bias.
    always_comb begin
        beat_s     = (state_r == ST_ACCUM) && in_valid;
        last_s     = beat_s && (idx_r == IDX_W'(N_INPUTS - 1));
        in_ext_s   = {{DATA_W{in_data[DATA_W-1]}}, in_data};
        w_ext_s    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
        prod_s     = in_ext_s * w_ext_s;
        prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
        bias_ext_s = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
        acc_bias_s = acc_r + bias_ext_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start outside IDLE is simply dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_ACCUM;
                else       state_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (last_s) state_s = ST_BIAS;
                else        state_s = ST_ACCUM;
            end
            ST_BIAS: state_s = ST_OUT;
            ST_OUT: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Accumulator, index, neuron latch and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= '0;
            idx_r    <= '0;
            nid_r    <= '0;
            result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nid_r <= neuron_id;
                        acc_r <= '0;
                        idx_r <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (beat_s) begin
                        acc_r <= acc_r + prod_ext_s;
                        idx_r <= idx_r + IDX_W'(1'b1);
                    end
                end
                ST_BIAS: begin
                    acc_r    <= acc_bias_s;
                    result_r <= sat_relu(acc_bias_s >>> FRAC_W);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so no ready/valid combinational loop.
    always_comb begin
        in_ready  = (state_r == ST_ACCUM);
        out_valid = (state_r == ST_OUT);
        busy      = (state_r != ST_IDLE);
        out_data  = result_r;
        w_addr    = {nid_r, idx_r};
    end

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// Scoreboard bench for mlp_neuron_mac: ReLU and linear instances share stimulus,
// expected results are queued at start and popped by per-instance monitors.
module tb_mlp_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  neuron_id;
    logic [15:0] bias;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_r, out_valid_r, busy_r;
    logic        in_ready_l, out_valid_l, busy_l;
    logic [23:0] w_addr_r, w_addr_l;
    logic [15:0] w_data_r, w_data_l;
    logic [15:0] out_data_r, out_data_l;

    int din[4];
    int wtab[4];
    logic [15:0] q_r[$];
    logic [15:0] q_l[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Asynchronous-read weight regfile model indexed by the low address bits.
    always_comb begin
        w_data_r = 16'(wtab[w_addr_r[1:0]]);
        w_data_l = 16'(wtab[w_addr_l[1:0]]);
    end

    mlp_neuron_mac #(.DATA_W(16), .FRAC_W(8), .N_INPUTS(4), .IDX_W(16),
                     .NID_W(8), .ACC_W(48), .RELU_EN(1'b1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_id(neuron_id),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .w_addr(w_addr_r), .w_data(w_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .busy(busy_r));

    mlp_neuron_mac #(.DATA_W(16), .FRAC_W(8), .N_INPUTS(4), .IDX_W(16),
                     .NID_W(8), .ACC_W(48), .RELU_EN(1'b0)) dut_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_id(neuron_id),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .w_addr(w_addr_l), .w_data(w_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .busy(busy_l));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference neuron: exact integer dot product, bias in Q format, floor
    // division by 2^8, clamp to 16-bit signed, optional ReLU.
    function automatic logic [15:0] model(input int b, input bit relu);
        longint s = 0;
        longint rem;
        longint q;
        for (int i = 0; i < 4; i++) s += longint'(din[i]) * longint'(wtab[i]);
        s += longint'(b) * 256;
        rem = s % 256;
        if (rem < 0) rem += 256;
        q = (s - rem) / 256;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return q[15:0];
    endfunction

    // Monitors: a result is consumed on each out_valid/out_ready handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid_r && out_ready) begin
            if (q_r.size() == 0) begin
                total++; bad++;
                $display("FAIL relu_unexpected_result: got %0h expected none", out_data_r);
            end else begin
                chk("relu_result", out_data_r, q_r.pop_front());
            end
        end
        if (rst_n && out_valid_l && out_ready) begin
            if (q_l.size() == 0) begin
                total++; bad++;
                $display("FAIL lin_unexpected_result: got %0h expected none", out_data_l);
            end else begin
                chk("lin_result", out_data_l, q_l.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  {in_ready_r, in_ready_l}, 0);
        chk({tag, "_out_valid"}, {out_valid_r, out_valid_l}, 0);
        chk({tag, "_busy"},      {busy_r, busy_l}, 0);
        chk({tag, "_w_addr"},    {w_addr_r, w_addr_l}, 0);
        chk({tag, "_out_data"},  {out_data_r, out_data_l}, 0);
    endtask

    task automatic run_neuron(input logic [7:0] nid, input int b, input int prob,
                              input int hold, input bit spur, input bit have_exp,
                              input logic [15:0] er, input logic [15:0] el);
        int beat = 0;
        int cyc = 0;
        bit acc;
        logic [15:0] snap_r, snap_l;
        bias = 16'(b);
        while ((busy_r || busy_l) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        start = 1'b1; neuron_id = nid;
        @(posedge clk); #1;
        start = 1'b0; neuron_id = 8'($urandom);
        if (have_exp) begin
            q_r.push_back(er); q_l.push_back(el);
        end else begin
            q_r.push_back(model(b, 1'b1)); q_l.push_back(model(b, 1'b0));
        end
        cyc = 0;
        while (beat < 4 && cyc < 300) begin
            chk("w_addr_step", w_addr_r, {nid, 16'(beat)});
            in_valid  = ($urandom_range(0, 99) < prob);
            in_data   = in_valid ? 16'(din[beat]) : 16'($urandom);
            start     = spur && (cyc == 2);
            neuron_id = start ? 8'd7 : 8'($urandom);
            acc = in_valid && in_ready_r && in_ready_l;
            @(posedge clk); #1;
            cyc++;
            if (acc) beat++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (beat < 4) begin
            total++; bad++;
            $display("FAIL beat_timeout: got %0d beats expected 4", beat);
        end
        chk("valid_low_in_bias", {out_valid_r, out_valid_l}, 0);
        @(posedge clk); #1;
        chk("valid_two_after_last", {out_valid_r, out_valid_l}, 2'b11);
        snap_r = out_data_r; snap_l = out_data_l;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_data", {out_data_r, out_data_l}, {snap_r, snap_l});
            chk("hold_out_valid", {out_valid_r, out_valid_l}, 2'b11);
            chk("hold_w_addr_nid", w_addr_r[23:16], nid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_handshake", {busy_r, busy_l}, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; neuron_id = 8'd0; bias = 16'd0;
        in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin din[i] = 0; wtab[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic MAC
        for (int i = 0; i < 4; i++) begin din[i] = 256; wtab[i] = 256; end
        run_neuron(8'd1, 0, 100, 0, 1'b0, 1'b1, 16'h0400, 16'h0400);
        // bias and ReLU
        for (int i = 0; i < 4; i++) wtab[i] = -256;
        run_neuron(8'd2, 512, 100, 0, 1'b0, 1'b1, 16'h0000, 16'hFE00);
        // positive and negative saturation
        for (int i = 0; i < 4; i++) begin din[i] = 32767; wtab[i] = 32767; end
        run_neuron(8'd3, 0, 100, 0, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) din[i] = -32768;
        run_neuron(8'd4, 0, 100, 0, 1'b0, 1'b1, 16'h0000, 16'h8000);
        // backpressure, addressing, ignored start from neuron 7
        din = '{100, -200, 300, -400};
        wtab = '{256, 512, -128, 64};
        run_neuron(8'd5, -3, 50, 10, 1'b1, 1'b0, 16'd0, 16'd0);

        // reset after two accepted beats
        for (int i = 0; i < 4; i++) begin din[i] = 1000; wtab[i] = 700; end
        start = 1'b1; neuron_id = 8'd9;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 16'd1000;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_w_addr", w_addr_r, {8'd9, 16'd2});
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin din[i] = 256; wtab[i] = 256; end
        run_neuron(8'd6, 0, 100, 0, 1'b0, 1'b1, 16'h0400, 16'h0400);

        // randomized neurons checked against the reference model
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n % 2 == 0) begin
                    din[i]  = int'($urandom_range(0, 1024)) - 512;
                    wtab[i] = int'($urandom_range(0, 1024)) - 512;
                end else begin
                    din[i]  = int'($signed(16'($urandom)));
                    wtab[i] = int'($signed(16'($urandom)));
                end
            end
            run_neuron(8'($urandom), int'($signed(16'($urandom))),
                       int'($urandom_range(30, 100)), int'($urandom_range(0, 5)),
                       1'b0, 1'b0, 16'd0, 16'd0);
        end

        repeat (3) @(posedge clk);
        chk("relu_queue_drained", q_r.size(), 0);
        chk("lin_queue_drained", q_l.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
